data_pipe_path_scheduler: RTL and testbench



---
 rtl/data_pipe_path_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_data_pipe_path_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pipe_path_scheduler.sv
// -----------------------------------------------------------------------------
// data_pipe_path_scheduler
//
// Round-robin scheduler for the 1-to-8 data_pipe interconnect. It picks one
// requesting downstream path and drives the interconnect path select
// (sw/sw_vld). It also gates the upstream stream, so the select only changes
// while the interconnect is drained. A grant lasts one burst. The burst ends on
// a tagged last beat, on the beat limit, or when the grantee withdraws its
// request.
//
// Ports
//   clock      system clock
//   rst_n      asynchronous active-low reset
//   clk_en     clock enable; qualifies every state change, count and accept
//   req[7:0]   per-path request
//   src_valid  upstream valid
//   src_last   upstream last-beat tag (sampled with src_valid)
//   src_ready  ready to upstream
//   ic_valid   valid to interconnect s00
//   ic_ready   ready from interconnect s00
//   sw[2:0]    path index to interconnect
//   sw_vld     path index valid
//   grant[7:0] one-hot current path, zero when none
//   busy       high in every state but IDLE
//   beat_cnt   beats accepted in the current grant
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no request pending, select invalid
// ARB    | one-cycle round-robin search starting after the last winner
// SETTLE | select valid, stream still closed while the switch settles
// GRANT  | stream open, beats flow to the selected path
// DRAIN  | stream closed, select held until the interconnect has emptied
// -----------------------------------------------------------------------------
module data_pipe_path_scheduler #(
    parameter int MAX_BEATS  = 16,
    parameter int SETTLE_CYC = 2,
    parameter int DRAIN_CYC  = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [7:0] req,
    input  logic       src_valid,
    input  logic       src_last,
    output logic       src_ready,
    output logic       ic_valid,
    input  logic       ic_ready,
    output logic [2:0] sw,
    output logic       sw_vld,
    output logic [7:0] grant,
    output logic       busy,
    output logic [7:0] beat_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        SETTLE = 3'd2,
        GRANT  = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_B8    = 8'(MAX_BEATS);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] DRAIN_LD  = 4'(DRAIN_CYC - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [3:0] tmr, tmr_nxt;
    logic [2:0] sw_nxt;
    logic       sw_vld_nxt;
    logic [7:0] grant_nxt;
    logic [7:0] beat_nxt;

    logic       arb_found;
    logic [2:0] arb_idx;
    logic [2:0] cand;
    logic       accept;
    logic [7:0] beat_inc;

    // Stream gating is purely combinational on state, so an async reset
    // closes the stream at once without waiting for an edge.
    assign ic_valid  = src_valid & (state == GRANT);
    assign src_ready = ic_ready & (state == GRANT);
    assign busy      = (state != IDLE);
    assign accept    = ic_valid & ic_ready & clk_en;
    assign beat_inc  = beat_cnt + 8'd1;

    // Search ptr+1 .. ptr+8 (mod 8). The last grantee is checked last, so it
    // has the lowest priority.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr;
        cand      = ptr;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        tmr_nxt    = tmr;
        sw_nxt     = sw;
        sw_vld_nxt = sw_vld;
        grant_nxt  = grant;
        beat_nxt   = beat_cnt;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    if (|req) state_nxt = ARB;
                end
                ARB: begin
                    if (arb_found) begin
                        state_nxt  = SETTLE;
                        sw_nxt     = arb_idx;
                        sw_vld_nxt = 1'b1;
                        grant_nxt  = 8'd1 << arb_idx;
                        ptr_nxt    = arb_idx;
                        beat_nxt   = 8'd0;
                        tmr_nxt    = SETTLE_LD;
                    end else begin
                        state_nxt  = IDLE;
                        sw_vld_nxt = 1'b0;
                        grant_nxt  = 8'd0;
                    end
                end
                SETTLE: begin
                    if (tmr == 4'd0) state_nxt = GRANT;
                    else             tmr_nxt   = tmr - 4'd1;
                end
                GRANT: begin
                    // An accept always counts. A request drop in the same
                    // cycle only closes the burst after that beat.
                    if (accept) begin
                        if (beat_cnt != MAX_B8) beat_nxt = beat_inc;
                        if (src_last || (beat_inc == MAX_B8)) begin
                            state_nxt = DRAIN;
                            tmr_nxt   = DRAIN_LD;
                        end else if (!req[sw]) begin
                            state_nxt = DRAIN;
                            tmr_nxt   = DRAIN_LD;
                        end
                    end else if (!req[sw]) begin
                        state_nxt = DRAIN;
                        tmr_nxt   = DRAIN_LD;
                    end
                end
                DRAIN: begin
                    if (tmr == 4'd0) begin
                        sw_vld_nxt = 1'b0;
                        grant_nxt  = 8'd0;
                        state_nxt  = (|req) ? ARB : IDLE;
                    end else begin
                        tmr_nxt = tmr - 4'd1;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    sw_vld_nxt = 1'b0;
                    grant_nxt  = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd7;
            tmr      <= 4'd0;
            sw       <= 3'd0;
            sw_vld   <= 1'b0;
            grant    <= 8'd0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            tmr      <= tmr_nxt;
            sw       <= sw_nxt;
            sw_vld   <= sw_vld_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_data_pipe_path_scheduler.sv
module tb_data_pipe_path_scheduler;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] req;
    logic       src_valid;
    logic       src_last;
    logic       src_ready;
    logic       ic_valid;
    logic       ic_ready;
    logic [2:0] sw;
    logic       sw_vld;
    logic [7:0] grant;
    logic       busy;
    logic [7:0] beat_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    data_pipe_path_scheduler #(
        .MAX_BEATS (4),
        .SETTLE_CYC(2),
        .DRAIN_CYC (4)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .req      (req),
        .src_valid(src_valid),
        .src_last (src_last),
        .src_ready(src_ready),
        .ic_valid (ic_valid),
        .ic_ready (ic_ready),
        .sw       (sw),
        .sw_vld   (sw_vld),
        .grant    (grant),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    typedef struct {
        logic [7:0] req;
        logic       sv;
        logic       sl;
        logic       en;
        logic [2:0] sw;
        logic       vld;
        logic [7:0] grant;
        logic       busy;
        logic       iv;
        logic       sr;
        logic [7:0] beat;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic [7:0] r, logic sv, logic sl, logic en,
                                logic [2:0] s, logic v, logic [7:0] g,
                                logic b, logic iv, logic sr, logic [7:0] bc);
        vec_t t;
        t.req = r;  t.sv = sv; t.sl = sl; t.en = en;
        t.sw = s;   t.vld = v; t.grant = g; t.busy = b;
        t.iv = iv;  t.sr = sr; t.beat = bc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] pack_out();
        return {sw, sw_vld, grant, busy, ic_valid, src_ready, beat_cnt};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00; src_valid = 1'b0; src_last = 1'b0;
        ic_ready = 1'b1; clk_en = 1'b1;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin
        // single-path burst, then clk_en hold in IDLE/ARB
        //             req    sv sl en  sw vld grant busy iv sr beat
        tbl[0]  = mk(8'h04, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
        tbl[1]  = mk(8'h04, 1, 0, 1, 2, 1, 8'h04, 1, 0, 0, 0);
        tbl[2]  = mk(8'h04, 1, 0, 1, 2, 1, 8'h04, 1, 0, 0, 0);
        tbl[3]  = mk(8'h04, 1, 0, 1, 2, 1, 8'h04, 1, 1, 1, 0);
        tbl[4]  = mk(8'h04, 1, 0, 1, 2, 1, 8'h04, 1, 1, 1, 1);
        tbl[5]  = mk(8'h04, 1, 0, 1, 2, 1, 8'h04, 1, 1, 1, 2);
        tbl[6]  = mk(8'h04, 1, 1, 1, 2, 1, 8'h04, 1, 0, 0, 3);
        tbl[7]  = mk(8'h00, 0, 0, 1, 2, 1, 8'h04, 1, 0, 0, 3);
        tbl[8]  = mk(8'h00, 0, 0, 1, 2, 1, 8'h04, 1, 0, 0, 3);
        tbl[9]  = mk(8'h00, 0, 0, 1, 2, 1, 8'h04, 1, 0, 0, 3);
        tbl[10] = mk(8'h00, 0, 0, 1, 2, 0, 8'h00, 0, 0, 0, 3);
        tbl[11] = mk(8'h04, 0, 0, 0, 2, 0, 8'h00, 0, 0, 0, 3);
        tbl[12] = mk(8'h04, 0, 0, 1, 2, 0, 8'h00, 1, 0, 0, 3);
        tbl[13] = mk(8'h04, 0, 0, 0, 2, 0, 8'h00, 1, 0, 0, 3);
        tbl[14] = mk(8'h04, 0, 0, 1, 2, 1, 8'h04, 1, 0, 0, 0);

        // reset values, with upstream already offering data
        rst_n = 1'b0;
        req = 8'hFF; src_valid = 1'b1; src_last = 1'b0;
        ic_ready = 1'b1; clk_en = 1'b1;
        #3;
        check("reset_outputs", 32'(pack_out()), 32'd0);
        do_reset();

        // table-driven single-path sequence
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].req; src_valid = tbl[i].sv;
            src_last = tbl[i].sl; clk_en = tbl[i].en; ic_ready = 1'b1;
            @(posedge clock); #1;
            if (pack_out() !== {tbl[i].sw, tbl[i].vld, tbl[i].grant, tbl[i].busy,
                                tbl[i].iv, tbl[i].sr, tbl[i].beat}) begin
                tests++;
                fails++;
                $display("FAIL vec%0d: got sw=%0d vld=%0b grant=%h busy=%0b iv=%0b sr=%0b beat=%0d expected sw=%0d vld=%0b grant=%h busy=%0b iv=%0b sr=%0b beat=%0d",
                         i, sw, sw_vld, grant, busy, ic_valid, src_ready, beat_cnt,
                         tbl[i].sw, tbl[i].vld, tbl[i].grant, tbl[i].busy,
                         tbl[i].iv, tbl[i].sr, tbl[i].beat);
            end else begin
                tests++;
            end
        end

        // round robin over paths 0, 3, 7 with one-beat bursts
        begin
            logic [7:0] exp_g[5];
            int n;
            exp_g[0] = 8'h01; exp_g[1] = 8'h08; exp_g[2] = 8'h80;
            exp_g[3] = 8'h01; exp_g[4] = 8'h08;
            do_reset();
            req = 8'h89; src_valid = 1'b1; src_last = 1'b1;
            n = 0;
            for (int c = 0; c < 200 && n < 5; c++) begin
                @(negedge clock);
                if (ic_valid) begin
                    check($sformatf("rr_grant%0d", n), 32'(grant), 32'(exp_g[n]));
                    n++;
                end
            end
            check("rr_count", 32'(n), 32'd5);
        end

        // MAX_BEATS limit: continuous stream with no last tag
        begin
            int n;
            int extra;
            logic done;
            do_reset();
            req = 8'h01; src_valid = 1'b1; src_last = 1'b0;
            n = 0; done = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                @(negedge clock);
                if (ic_valid && src_ready) begin
                    n++;
                    if (n == 4) begin
                        @(negedge clock);
                        check("max_ready_closed", 32'(src_ready), 32'd0);
                        check("max_beat_cnt", 32'(beat_cnt), 32'd4);
                        done = 1'b1;
                    end
                end
            end
            check("max_reached", 32'(done), 32'd1);
            extra = 0;
            repeat (6) begin
                @(negedge clock);
                if (src_ready) extra++;
            end
            check("max_no_extra_accepts", 32'(extra), 32'd0);
            @(negedge clock);
            check("max_regrant_ready", 32'(src_ready), 32'd1);
            check("max_regrant_path", 32'(grant), 32'h01);
            check("max_regrant_beat", 32'(beat_cnt), 32'd0);
        end

        // backpressure and clock enable
        begin
            int exp_beat;
            int total;
            logic acc, arb, prev_iv;
            logic [2:0] prev_sw;
            do_reset();
            req = 8'h02; src_valid = 1'b1; src_last = 1'b0;
            exp_beat = 0; total = 0; prev_iv = 1'b0; prev_sw = 3'd0;
            @(posedge clock); #1;
            for (int k = 0; k < 48; k++) begin
                ic_ready = (k % 2 == 0);
                clk_en   = (k % 3 != 2);
                @(negedge clock);
                acc = ic_valid & ic_ready & clk_en;
                arb = busy & ~sw_vld & clk_en & (req != 8'h00);
                if (ic_valid) begin
                    check("bp_vld_with_valid", 32'(sw_vld), 32'd1);
                    if (prev_iv) check("bp_sw_stable", 32'(sw), 32'(prev_sw));
                end
                prev_iv = ic_valid;
                prev_sw = sw;
                @(posedge clock); #1;
                if (arb)      exp_beat = 0;
                else if (acc) exp_beat = exp_beat + 1;
                if (acc) total++;
                check($sformatf("bp_beat_k%0d", k), 32'(beat_cnt), 32'(exp_beat));
            end
            check("bp_progress", 32'(total >= 4), 32'd1);
            clk_en = 1'b1; ic_ready = 1'b1;
        end

        // request withdrawal on path 5 with no beat in that cycle
        begin
            logic got;
            do_reset();
            req = 8'h20; src_valid = 1'b0; src_last = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(posedge clock); #1;
                if (src_ready) got = 1'b1;
            end
            check("wd_granted", 32'(got), 32'd1);
            req = 8'h44;
            @(posedge clock); #1;
            check("wd_drain_closed", 32'(src_ready), 32'd0);
            check("wd_drain_sel", 32'({sw_vld, sw}), 32'({1'b1, 3'd5}));
            repeat (3) @(posedge clock);
            #1;
            check("wd_drain_hold", 32'(sw_vld), 32'd1);
            @(posedge clock); #1;
            check("wd_arb", 32'({busy, sw_vld, grant}), 32'({1'b1, 1'b0, 8'h00}));
            @(posedge clock); #1;
            check("wd_next_path", 32'(grant), 32'h40);
        end

        // asynchronous reset in the middle of a burst
        begin
            logic got;
            do_reset();
            req = 8'h01; src_valid = 1'b1; src_last = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(posedge clock); #1;
                if (src_ready) got = 1'b1;
            end
            check("ar_granted", 32'(got), 32'd1);
            repeat (2) @(posedge clock);
            @(negedge clock);
            check("ar_pre_beat", 32'(beat_cnt), 32'd2);
            rst_n = 1'b0;
            #1;
            check("ar_outputs_zero",
                  32'({sw_vld, ic_valid, grant, busy, beat_cnt}), 32'd0);
            @(negedge clock);
            req = 8'h81;
            rst_n = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(posedge clock); #1;
                if (grant != 8'h00) got = 1'b1;
            end
            check("ar_first_priority", 32'(grant), 32'h01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
